// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// Also holds the fetch reset vector that benches use as their first address.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned ADDR_W       = 32;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    function automatic int unsigned off_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned line_words,
                                             input int unsigned num_lines);
        return ADDR_W - 2 - off_bits(line_words) - idx_bits(num_lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: asynchronous reads, synchronous word and tag writes,
// and a flash-clear of all valid bits. Only the valid bits are reset.
module icache_array
    import icache_pkg::*;
#(
    parameter  int unsigned LINE_WORDS = 4,
    parameter  int unsigned NUM_LINES  = 64,
    localparam int unsigned OFF_W      = off_bits(LINE_WORDS),
    localparam int unsigned IDX_W      = idx_bits(NUM_LINES),
    localparam int unsigned TAG_W      = tag_bits(LINE_WORDS, NUM_LINES)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [WORD_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  tag_idx,
    input  logic [TAG_W-1:0]  tag_data,
    input  logic              set_valid,
    input  logic              clear_valid
);

    logic [WORD_W-1:0]    data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            data_mem[{wr_idx, wr_off}] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (tag_we) begin
            tag_mem[tag_idx] <= tag_data;
        end
    end

    // Flash-clear wins over a same-cycle install so a flushed line never survives.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
        end else if (clear_valid) begin
            valid <= '0;
        end else if (tag_we && set_valid) begin
            valid[tag_idx] <= 1'b1;
        end
    end

    assign rd_data  = data_mem[{rd_idx, rd_off}];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit lookup and a
// line-fill FSM (request, grant, in-order beats) towards main memory.
module instr_cache
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr_address_fIF,
    output logic [31:0] Instr1_2IF,
    output logic        Instr1_2IF_IsValid,
    input  logic        Flush,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Gnt,
    input  logic [31:0] Mem_Data,
    input  logic        Mem_Data_Valid
);

    localparam int unsigned OFF_W    = off_bits(LINE_WORDS);
    localparam int unsigned IDX_W    = idx_bits(NUM_LINES);
    localparam int unsigned TAG_W    = tag_bits(LINE_WORDS, NUM_LINES);
    localparam int unsigned LINE_LSB = OFF_W + 2;

    state_t             state;
    logic [OFF_W-1:0]   beat_cnt;
    logic               flush_pending;

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic [WORD_W-1:0]  rd_data;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               hit;
    logic               beat;
    logic               last_beat;
    logic               unused_byte_bits;

    // Byte position within a word does not matter for word-sized fetches.
    assign unused_byte_bits = ^Instr_address_fIF[1:0];

    assign req_off  = Instr_address_fIF[LINE_LSB-1:2];
    assign req_idx  = Instr_address_fIF[LINE_LSB +: IDX_W];
    assign req_tag  = Instr_address_fIF[ADDR_W-1 -: TAG_W];
    assign fill_idx = Mem_Addr[LINE_LSB +: IDX_W];
    assign fill_tag = Mem_Addr[ADDR_W-1 -: TAG_W];

    assign hit                = (state == IDLE) && rd_valid && (rd_tag == req_tag);
    assign Instr1_2IF_IsValid = hit;
    assign Instr1_2IF         = hit ? rd_data : '0;

    assign beat      = (state == FILL) && Mem_Data_Valid;
    assign last_beat = beat && (beat_cnt == OFF_W'(LINE_WORDS - 1));

    icache_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_array (
        .CLK         (CLK),
        .RESET       (RESET),
        .rd_idx      (req_idx),
        .rd_off      (req_off),
        .rd_data     (rd_data),
        .rd_tag      (rd_tag),
        .rd_valid    (rd_valid),
        .wr_en       (beat),
        .wr_idx      (fill_idx),
        .wr_off      (beat_cnt),
        .wr_data     (Mem_Data),
        .tag_we      (last_beat),
        .tag_idx     (fill_idx),
        .tag_data    (fill_tag),
        .set_valid   (!flush_pending && !Flush),
        .clear_valid (Flush)
    );

    // Fill FSM; Mem_Addr only moves when leaving IDLE, so it is stable for the whole fill.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            flush_pending <= 1'b0;
            Mem_Req       <= 1'b0;
            Mem_Addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit && !Flush) begin
                        state    <= REQ;
                        Mem_Req  <= 1'b1;
                        Mem_Addr <= {Instr_address_fIF[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                    end
                end
                REQ: begin
                    if (Flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (Mem_Gnt) begin
                        state   <= FILL;
                        Mem_Req <= 1'b0;
                    end
                end
                FILL: begin
                    if (Flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (Mem_Data_Valid) begin
                        beat_cnt <= beat_cnt + OFF_W'(1);
                        if (last_beat) begin
                            state         <= IDLE;
                            flush_pending <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Mem_Req <= 1'b0;
                end
            endcase
        end
    end

endmodule
